// File: rtl/axistream_unpack.sv
// Wide-to-narrow AXI-Stream converter: one NUM_PACK-element word in, one element per beat out, element 0 first.
// Optional macro AXISTREAM_UNPACK_WORD_TLAST_EN: tlast on the final element of every word, src_tlast ignored.
module axistream_unpack #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         src_tvalid,
  output logic                         src_tready,
  input  logic [NUM_PACK*DATA_WIDTH-1:0] src_tdata,
  input  logic                         src_tlast,
  output logic                         dest_tvalid,
  input  logic                         dest_tready,
  output logic [DATA_WIDTH-1:0]        dest_tdata,
  output logic                         dest_tlast
);

  localparam int CW = (NUM_PACK > 1) ? $clog2(NUM_PACK) : 1;
  localparam int WW = NUM_PACK * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PACK - 1);

  generate
    if (NUM_PACK < 2) begin : g_bad_num_pack
      $error("axistream_unpack: NUM_PACK must be >= 2");
    end
  endgenerate

  logic [WW-1:0] slot_q [2];
  logic [WW-1:0] slot_d [2];
  logic [1:0]    occ_q, occ_d;
  logic          hd_q, hd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop, pop_word, tail;

  assign src_tready  = !rst && (occ_q != 2'd2);
  assign dest_tvalid = (occ_q != 2'd0);
  assign push        = src_tvalid && src_tready;
  assign pop         = dest_tvalid && dest_tready;
  assign pop_word    = pop && (cnt_q == LAST_IDX);
  // Tail is the slot after head when one word is buffered, head itself when empty.
  assign tail        = hd_q ^ occ_q[0];

  assign dest_tdata  = slot_q[hd_q][int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    slot_d = slot_q;
    occ_d  = occ_q;
    hd_d   = hd_q;
    cnt_d  = cnt_q;
    if (pop) begin
      cnt_d = pop_word ? '0 : cnt_q + 1'b1;
    end
    if (pop_word) begin
      hd_d = ~hd_q;
    end
    if (push) begin
      slot_d[tail] = src_tdata;
    end
    case ({push, pop_word})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      occ_q     <= '0;
      hd_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
      occ_q     <= occ_d;
      hd_q      <= hd_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef AXISTREAM_UNPACK_WORD_TLAST_EN
  logic unused_src_tlast;
  assign unused_src_tlast = src_tlast;
  assign dest_tlast       = dest_tvalid && (cnt_q == LAST_IDX);
`else
  logic [1:0] tl_q, tl_d;

  always_comb begin
    tl_d = tl_q;
    if (push) begin
      tl_d[tail] = src_tlast;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tl_q <= '0;
    end else begin
      tl_q <= tl_d;
    end
  end

  assign dest_tlast = dest_tvalid && (cnt_q == LAST_IDX) && tl_q[hd_q];
`endif

endmodule

// File: tb/tb_axistream_unpack.sv
// Self-checking bench for axistream_unpack (DATA_WIDTH=8, NUM_PACK=4): vector table feeding a scoreboard queue.
module tb_axistream_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        src_tvalid;
  logic        src_tready;
  logic [31:0] src_tdata;
  logic        src_tlast;
  logic        dest_tvalid;
  logic        dest_tready;
  logic [7:0]  dest_tdata;
  logic        dest_tlast;

  axistream_unpack #(.DATA_WIDTH(8), .NUM_PACK(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_tvalid  (src_tvalid),
    .src_tready  (src_tready),
    .src_tdata   (src_tdata),
    .src_tlast   (src_tlast),
    .dest_tvalid (dest_tvalid),
    .dest_tready (dest_tready),
    .dest_tdata  (dest_tdata),
    .dest_tlast  (dest_tlast)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]     word;
    logic            last;
    logic [3:0][7:0] beat;
    logic [3:0]      blast;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  vec_t tbl [10];
  exp_t exp_q [$];
  int   cur_idx = 0;
  int   checks = 0;
  int   failures = 0;
  logic bp_en = 1'b0;

  function automatic vec_t mk(input logic [31:0] w, input logic l,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    vec_t v;
    v.word = w;
    v.last = l;
    v.beat = {b3, b2, b1, b0};
`ifdef AXISTREAM_UNPACK_WORD_TLAST_EN
    v.blast = 4'b1000;
`else
    v.blast = l ? 4'b1000 : 4'b0000;
`endif
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present word idx until accepted; n returns the number of cycles it was offered.
  task automatic send(input int idx, output int n);
    logic acc;
    src_tvalid = 1'b1;
    src_tdata  = tbl[idx].word;
    src_tlast  = tbl[idx].last;
    cur_idx    = idx;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = src_tready;
      tick();
      n++;
    end
    if (!acc) chk("src_accept_timeout", 32'd0, 32'd1);
    src_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    chk("drain", exp_q.size(), 0);
  endtask

  // Scoreboard: compare accepted beats, flag stalls while data is owed, enqueue accepted words.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() != 0 && dest_tready) begin
        chk("no_gap_valid", dest_tvalid, 1'b1);
      end
      if (dest_tvalid && dest_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("beat_data", dest_tdata, e.d);
          chk("beat_last", dest_tlast, e.l);
        end
      end
      if (src_tvalid && src_tready) begin
        for (int unsigned k = 0; k < 4; k++) begin
          exp_q.push_back({tbl[cur_idx].beat[k], tbl[cur_idx].blast[k]});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) dest_tready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = mk(32'h44332211, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
    tbl[1] = mk(32'h04030201, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04);
    tbl[2] = mk(32'h08070605, 1'b0, 8'h05, 8'h06, 8'h07, 8'h08);
    tbl[3] = mk(32'h0C0B0A09, 1'b1, 8'h09, 8'h0A, 8'h0B, 8'h0C);
    tbl[4] = mk(32'h44332211, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
    tbl[5] = mk(32'hA0A1A2A3, 1'b0, 8'hA3, 8'hA2, 8'hA1, 8'hA0);
    tbl[6] = mk(32'hB0B1B2B3, 1'b1, 8'hB3, 8'hB2, 8'hB1, 8'hB0);
    tbl[7] = mk(32'h5A6B7C8D, 1'b0, 8'h8D, 8'h7C, 8'h6B, 8'h5A);
    tbl[8] = mk(32'h7F80FF01, 1'b1, 8'h01, 8'hFF, 8'h80, 8'h7F);
    tbl[9] = mk(32'hDDCCBBAA, 1'b1, 8'hAA, 8'hBB, 8'hCC, 8'hDD);

    rst = 1'b1; src_tvalid = 1'b0; src_tdata = '0; src_tlast = 1'b0; dest_tready = 1'b0;
    repeat (3) tick();
    chk("rst_src_tready", src_tready, 1'b0);
    chk("rst_dest_tvalid", dest_tvalid, 1'b0);
    chk("rst_dest_tdata", dest_tdata, 8'h00);
    chk("rst_dest_tlast", dest_tlast, 1'b0);
    rst = 1'b0;
    tick();
    chk("idle_src_tready", src_tready, 1'b1);
    chk("idle_dest_tvalid", dest_tvalid, 1'b0);

    // Single word, first element visible the cycle after acceptance
    dest_tready = 1'b1;
    send(0, n);
    chk("latency_valid", dest_tvalid, 1'b1);
    chk("latency_data", dest_tdata, 8'h11);
    wait_drain();
    chk("empty_valid", dest_tvalid, 1'b0);

    // Back-to-back words, buffer fills to two
    send(1, n);
    send(2, n);
    chk("full_src_tready", src_tready, 1'b0);
    send(3, n);
    wait_drain();

    // Backpressure hold, second word buffered, third refused until 0x44 pops
    dest_tready = 1'b0;
    send(4, n);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", dest_tvalid, 1'b1);
      chk("hold_data", dest_tdata, 8'h11);
      chk("hold_last", dest_tlast, 1'b0);
      tick();
    end
    send(5, n);
    chk("hold_full_tready", src_tready, 1'b0);
    src_tvalid = 1'b1; src_tdata = tbl[6].word; src_tlast = tbl[6].last; cur_idx = 6;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_refuse", src_tready, 1'b0);
    end
    dest_tready = 1'b1;
    send(6, n);
    chk("refill_cycles", n, 5);
    wait_drain();

    // Packet tlast across two words
    send(7, n);
    send(8, n);
    wait_drain();

    // Reset after two beats discards the rest
    send(0, n);
    tick();
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("rst_mid_valid", dest_tvalid, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_tready", src_tready, 1'b1);
    tick();
    chk("post_rst_no_beat", dest_tvalid, 1'b0);
    send(9, n);
    chk("post_rst_first", dest_tdata, 8'hAA);
    wait_drain();

    // Whole table under random backpressure
    bp_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(i, n);
    end
    wait_drain();
    bp_en = 1'b0;
    dest_tready = 1'b1;
    tick();
    chk("final_empty", dest_tvalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
